// File: rtl/alu_op_driver_if.sv
// Command and response channels between a command source and alu_op_driver.
// The master modport is the command source / response consumer side.
interface alu_op_driver_if #(
    parameter int DW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_a;
    logic [DW-1:0] cmd_b;
    logic [2:0]    cmd_op;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_a;
    logic [DW-1:0] rsp_b;
    logic [2:0]    rsp_op;
    logic [DW-1:0] rsp_r;
    logic          rsp_err;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_a, rsp_b, rsp_op, rsp_r, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        output cmd_ready, rsp_valid, rsp_a, rsp_b, rsp_op, rsp_r, rsp_err
    );
endinterface

// File: rtl/alu_op_driver.sv
// Drives one command at a time onto a combinational ALU, samples R after a settle window
// and returns {A,B,Op,R}. Define ALU_SELFCHECK_EN to build the result self-check model.
module alu_op_driver #(
    parameter int DW         = 8,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_driver_if.slave    bus,
    output logic [DW-1:0]     alu_a_o,
    output logic [DW-1:0]     alu_b_o,
    output logic [2:0]        alu_op_o,
    input  logic [DW-1:0]     alu_r_i,
    output logic              busy_o,
    output logic [CNT_W-1:0]  op_count_o,
    output logic [CNT_W-1:0]  err_count_o
);
    // A settle window of zero still needs one cycle for the ALU inputs to propagate.
    localparam int SETTLE_EFF = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
    localparam int SCW        = $clog2(SETTLE_EFF + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SCW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]      alu_a_q, alu_a_d;
    logic [DW-1:0]      alu_b_q, alu_b_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]      rsp_a_q, rsp_a_d;
    logic [DW-1:0]      rsp_b_q, rsp_b_d;
    logic [2:0]         rsp_op_q, rsp_op_d;
    logic [DW-1:0]      rsp_r_q, rsp_r_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;
    logic               sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
            rsp_op_q    <= '0;
            rsp_r_q     <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_a_q     <= rsp_a_d;
            rsp_b_q     <= rsp_b_d;
            rsp_op_q    <= rsp_op_d;
            rsp_r_q     <= rsp_r_d;
            op_count_q  <= op_count_d;
        end
    end

    // ALU inputs keep the last command after completion; only reset clears them.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_a_d     = rsp_a_q;
        rsp_b_d     = rsp_b_q;
        rsp_op_d    = rsp_op_q;
        rsp_r_d     = rsp_r_q;
        op_count_d  = op_count_q;
        sample      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    alu_a_d  = bus.cmd_a;
                    alu_b_d  = bus.cmd_b;
                    alu_op_d = bus.cmd_op;
                    cnt_d    = SCW'(SETTLE_EFF);
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == SCW'(1)) begin
                    sample      = 1'b1;
                    rsp_r_d     = alu_r_i;
                    rsp_a_d     = alu_a_q;
                    rsp_b_d     = alu_b_q;
                    rsp_op_d    = alu_op_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - SCW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ALU_SELFCHECK_EN
    logic [DW-1:0]    exp_r;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    // Reference ALU evaluated on the latched operands; results wrap to DW bits.
    always_comb begin
        exp_r = '0;
        unique case (alu_op_q)
            3'd0:    exp_r = alu_a_q + alu_b_q;
            3'd1:    exp_r = alu_a_q - alu_b_q;
            3'd2:    exp_r = alu_a_q & alu_b_q;
            3'd3:    exp_r = alu_a_q | alu_b_q;
            3'd4:    exp_r = alu_a_q ^ alu_b_q;
            3'd5:    exp_r = ~alu_a_q;
            3'd6:    exp_r = alu_a_q << 1;
            default: exp_r = alu_a_q >> 1;
        endcase
    end

    always_comb begin
        rsp_err_d   = rsp_err_q;
        err_count_d = err_count_q;
        if (sample) begin
            rsp_err_d = (alu_r_i != exp_r);
            if ((alu_r_i != exp_r) && (err_count_q != {CNT_W{1'b1}})) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            rsp_err_q   <= rsp_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.rsp_err = rsp_err_q;
    assign err_count_o = err_count_q;
`else
    assign bus.rsp_err = 1'b0;
    assign err_count_o = '0;
`endif

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_a     = rsp_a_q;
    assign bus.rsp_b     = rsp_b_q;
    assign bus.rsp_op    = rsp_op_q;
    assign bus.rsp_r     = rsp_r_q;
    assign alu_a_o       = alu_a_q;
    assign alu_b_o       = alu_b_q;
    assign alu_op_o      = alu_op_q;
    assign busy_o        = (state_q != IDLE);
    assign op_count_o    = op_count_q;

    // A stalled response must hold its payload until the consumer takes it.
    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.rsp_valid && !bus.rsp_ready) |=>
            (bus.rsp_valid && $stable(bus.rsp_r) && $stable(bus.rsp_a)
             && $stable(bus.rsp_b) && $stable(bus.rsp_op)));

endmodule
